uart_tx_fifo_reader: RTL and testbench
======================================

# uart_tx_fifo_reader

Read-side consumer of the transceiver's byte FIFO: pops one byte at a time from the dual-port RAM FIFO and serialises it on the UART line as an 8N1 frame (1 start bit, 8 data bits LSB first, 1 stop bit, no parity). It sits between the FIFO's read port and the TX pin, in the FIFO read clock domain. Bit timing comes from a parameterised clock-cycles-per-bit counter; no oversampling.

## Interface
- CLKS_PER_BIT, 104, clock cycles per UART bit (104 = 12 MHz / 115200); legal range 2..65535
- i_clk  in  1  clock, same clock as the FIFO read port
- reset  in  1  synchronous, active-high reset
- i_tx_en  in  1  enable: new bytes are popped only while high
- i_fifo_empty  in  1  FIFO empty flag
- i_fifo_rd_data  in  8  FIFO read data, valid one cycle after o_fifo_rd_en
- o_fifo_rd_en  out  1  FIFO pop strobe, one cycle per byte
- o_tx  out  1  serial line, idle high
- o_busy  out  1  high while a byte is being fetched or sent
- o_tx_done  out  1  one-cycle pulse at end of each frame

## Operation
- States: IDLE, FETCH, START, DATA, STOP.
- IDLE: o_tx=1. o_fifo_rd_en = (state==IDLE) & i_tx_en & !i_fifo_empty (combinational). If asserted -> FETCH next cycle.
- FETCH: one cycle; latch i_fifo_rd_data into 8-bit shift register; clear baud counter, bit index=0 -> START.
- START: o_tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: o_tx=shift[0]; after CLKS_PER_BIT cycles shift right, bit index+1; after bit 7 completes -> STOP.
- STOP: o_tx=1 for CLKS_PER_BIT cycles; o_tx_done=1 in the last STOP cycle -> IDLE.
- o_tx, o_busy, o_tx_done are registered (no glitches on o_tx). o_busy = state!=IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, width ceil(log2(CLKS_PER_BIT)); terminal count advances bit. Bit index 3 bits, wraps 7->0 on leaving DATA.
- i_tx_en low mid-frame: current frame completes normally; only the next pop is blocked.
- i_fifo_empty ignored outside IDLE; byte count is not tracked here.
- Exactly one o_fifo_rd_en pulse per frame; never asserted while i_fifo_empty=1.

## Timing
- Reset: state IDLE, o_tx=1, o_busy=0, o_tx_done=0, o_fifo_rd_en=0, shift reg 0, counters 0.
- Reset mid-frame: frame abandoned; o_tx=1 from the cycle after reset is sampled; popped byte is lost (not re-read).
- Pop at cycle N (o_fifo_rd_en=1) -> FETCH at N+1 (data sampled) -> o_tx falls at N+2, o_busy rises at N+1.
- Frame length on line: 10*CLKS_PER_BIT cycles; data bit k occupies cycles N+2+(k+1)*CLKS_PER_BIT .. +CLKS_PER_BIT-1.
- o_tx_done at cycle N+1+10*CLKS_PER_BIT; IDLE at next cycle.
- Back-to-back with FIFO non-empty: next pop in first IDLE cycle; 2 idle-high cycles (IDLE+FETCH) between stop bit and next start bit; frame period 10*CLKS_PER_BIT+2.
- i_fifo_empty asserted in same cycle as the would-be pop: no pop, remain IDLE.

## Test plan
- CLKS_PER_BIT=4, FIFO holds 0x55, i_tx_en=1 -> one rd_en pulse; o_tx: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), 1 for 4; o_tx_done once at pop+41; o_busy high 41 cycles.
- Byte 0xA3, CLKS_PER_BIT=4 -> data bits on line 1,1,0,0,0,1,0,1; receiver model decodes 0xA3, stop bit 1.
- FIFO holds 0x01,0xFF,0x80 -> three rd_en pulses spaced 42 cycles; exactly 2 high cycles between each stop and next start; decoded order preserved.
- i_fifo_empty=1 for 200 cycles or i_tx_en=0 with data -> o_fifo_rd_en never high, o_tx=1, o_busy=0.
- i_tx_en dropped during DATA of 0x3C -> frame completes and decodes 0x3C; no further pop until i_tx_en=1.
- reset pulsed during bit 3 of 0xF0 -> next cycle o_tx=1, o_busy=0, o_tx_done=0; after release next byte sent correctly.

Source files
------------

// File: rtl/uart_tx_fifo_reader_if.sv
// uart_tx_fifo_reader_if: FIFO read-port and UART line signals of the TX reader
interface uart_tx_fifo_reader_if;
    logic       i_tx_en;
    logic       i_fifo_empty;
    logic [7:0] i_fifo_rd_data;
    logic       o_fifo_rd_en;
    logic       o_tx;
    logic       o_busy;
    logic       o_tx_done;
    modport master (
        output i_tx_en, i_fifo_empty, i_fifo_rd_data,
        input  o_fifo_rd_en, o_tx, o_busy, o_tx_done
    );
    modport slave (
        input  i_tx_en, i_fifo_empty, i_fifo_rd_data,
        output o_fifo_rd_en, o_tx, o_busy, o_tx_done
    );
endinterface

// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: pops bytes from the read side of the FIFO and sends them as 8N1 UART frames
module uart_tx_fifo_reader #(
    parameter int CLKS_PER_BIT = 104
) (
    input logic                  i_clk,
    input logic                  reset,
    uart_tx_fifo_reader_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
    state_t        state;
    logic [7:0]    shift;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
    logic          last_tick;
    logic          pop;
    assign last_tick = baud_cnt == CW'(CLKS_PER_BIT - 1);
    assign pop = (state == IDLE) && bus.i_tx_en && !bus.i_fifo_empty && !reset;
    assign bus.o_fifo_rd_en = pop;
    assign bus.o_tx = tx_q;
    assign bus.o_busy = busy_q;
    assign bus.o_tx_done = done_q;
    // Frame sequencer; line, busy and done are registered so the next value is set on each transition
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        state  <= FETCH;
                        busy_q <= 1'b1;
                    end
                end
                FETCH: begin
                    shift    <= bus.i_fifo_rd_data;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    tx_q     <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (last_tick) begin
                        baud_cnt <= '0;
                        tx_q     <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        bit_idx  <= bit_idx + 3'd1;
                        tx_q     <= (bit_idx == 3'd7) ? 1'b1 : shift[1];
                        state    <= (bit_idx == 3'd7) ? STOP : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (last_tick) begin
                        baud_cnt <= '0;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                        done_q   <= baud_cnt == CW'(CLKS_PER_BIT - 2);
                    end
                end
                default: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb_uart_tx_fifo_reader: directed vectors with a FIFO model and a line decoder, CLKS_PER_BIT=4
module tb_uart_tx_fifo_reader;
    localparam int CPB = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_en = 1'b0;
    logic [7:0] rd_q = 8'h00;
    logic [7:0] mem [16];
    logic [3:0] wp = 4'd0;
    logic [3:0] rp = 4'd0;
    int cyc = 0;
    int vectors = 0;
    int errors = 0;
    typedef struct {
        logic [7:0] data;
        int         gap;
    } vec_t;
    vec_t tv [5];

    always #5 clk = ~clk;

    uart_tx_fifo_reader_if bus();
    uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB)) dut (.i_clk(clk), .reset(rst), .bus(bus.slave));

    assign bus.i_tx_en = tx_en;
    assign bus.i_fifo_empty = (wp == rp);
    assign bus.i_fifo_rd_data = rd_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.o_fifo_rd_en) begin
            rd_q <= mem[rp];
            rp <= rp + 4'd1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp] = b;
        wp = wp + 4'd1;
    endtask

    task automatic wait_pop(output int pop_cyc);
        int w;
        w = 0;
        #1;
        while (!bus.o_fifo_rd_en && w < 300) begin
            @(negedge clk);
            w++;
        end
        pop_cyc = bus.o_fifo_rd_en ? cyc : -1;
    endtask

    task automatic frame_check(input logic [7:0] b, input int drop_k, output int pop_cyc);
        int tx_bad, busy_bad, done_bad, rd_bad;
        logic [9:0] rx;
        logic exp_tx;
        tx_bad = 0; busy_bad = 0; done_bad = 0; rd_bad = 0; rx = '0;
        wait_pop(pop_cyc);
        if (pop_cyc < 0) begin
            chk("pop_timeout", 0, 1);
            return;
        end
        for (int k = 0; k <= 41; k++) begin
            if (k > 0) @(negedge clk);
            exp_tx = (k < 2) ? 1'b1 : (k < 6) ? 1'b0 : (k < 38) ? b[(k-6)/4] : 1'b1;
            if (bus.o_tx !== exp_tx) tx_bad++;
            if (bus.o_busy !== (k >= 1)) busy_bad++;
            if (bus.o_tx_done !== (k == 41)) done_bad++;
            if (k > 0 && bus.o_fifo_rd_en !== 1'b0) rd_bad++;
            if (k >= 4 && (k - 4) % 4 == 0) rx[(k-4)/4] = bus.o_tx;
            if (k == drop_k) tx_en = 1'b0;
        end
        chk("tx_wave_errs", tx_bad, 0);
        chk("busy_errs", busy_bad, 0);
        chk("done_errs", done_bad, 0);
        chk("extra_rd_en", rd_bad, 0);
        chk("rx_start", int'(rx[0]), 0);
        chk("rx_byte", int'(rx[8:1]), int'(b));
        chk("rx_stop", int'(rx[9]), 1);
    endtask

    task automatic idle_check(input int n, input string nm);
        int rd_cnt, tx_low, busy_cnt;
        rd_cnt = 0; tx_low = 0; busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.o_fifo_rd_en !== 1'b0) rd_cnt++;
            if (bus.o_tx !== 1'b1) tx_low++;
            if (bus.o_busy !== 1'b0) busy_cnt++;
        end
        chk({nm, "_rd_en"}, rd_cnt, 0);
        chk({nm, "_tx_low"}, tx_low, 0);
        chk({nm, "_busy"}, busy_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pc, last;
        tv[0] = '{8'h55, 0};
        tv[1] = '{8'hA3, 0};
        tv[2] = '{8'h01, 0};
        tv[3] = '{8'hFF, 42};
        tv[4] = '{8'h80, 42};
        last = 0;
        tx_en = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx", int'(bus.o_tx), 1);
        chk("reset_busy", int'(bus.o_busy), 0);
        chk("reset_done", int'(bus.o_tx_done), 0);
        chk("reset_rd_en", int'(bus.o_fifo_rd_en), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            if (tv[i].gap == 0) begin
                repeat (2) @(negedge clk);
                push(tv[i].data);
                for (int j = i + 1; j < 5 && tv[j].gap != 0; j++) push(tv[j].data);
            end
            frame_check(tv[i].data, -1, pc);
            if (tv[i].gap != 0) chk("pop_spacing", pc - last, tv[i].gap);
            last = pc;
        end

        idle_check(200, "empty");
        tx_en = 1'b0;
        push(8'h77);
        idle_check(50, "disabled");
        tx_en = 1'b1;
        frame_check(8'h77, -1, pc);

        repeat (2) @(negedge clk);
        push(8'h3C);
        push(8'h99);
        frame_check(8'h3C, 10, pc);
        idle_check(100, "dropped_en");
        tx_en = 1'b1;
        frame_check(8'h99, -1, pc);

        repeat (2) @(negedge clk);
        push(8'hF0);
        wait_pop(pc);
        chk("reset_seq_pop", int'(pc >= 0), 1);
        repeat (19) @(negedge clk);
        chk("pre_reset_bit3", int'(bus.o_tx), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midframe_reset_tx", int'(bus.o_tx), 1);
        chk("midframe_reset_busy", int'(bus.o_busy), 0);
        chk("midframe_reset_done", int'(bus.o_tx_done), 0);
        chk("midframe_reset_rd_en", int'(bus.o_fifo_rd_en), 0);
        rst = 1'b0;
        idle_check(10, "after_reset");
        push(8'h5A);
        frame_check(8'h5A, -1, pc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
